// File: rtl/seq_det_arb.sv
// -----------------------------------------------------------------------------
// seq_det_arb
//
// Round-robin scheduler that time-shares one serial sequence detector among
// NREQ requesting channels. Each grant flushes the detector with two zero
// bits, streams FRAME_LEN bits from the winning channel into it, and counts
// the detector hits that belong to that frame. A tagged result is strobed
// once per frame.
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset_n    asynchronous reset, active low
//   i_ch_req     per-channel frame request, held high for the whole frame
//   i_ch_bit     per-channel serial data (bit k presented in STREAM cycle k)
//   o_ch_grant   one-hot grant, high only in STREAM cycles that consume a bit
//   o_det_seq_in serial bit to the shared detector
//   i_det_hit    detector Moore output (reflects the previous cycle's bit)
//   o_res_valid  one-cycle result strobe
//   o_res_ch     channel of the reported frame (held until next report)
//   o_res_count  saturating hit count of the frame (held until next report)
//   o_res_abort  frame ended early by a request drop (held until next report)
// -----------------------------------------------------------------------------
module seq_det_arb #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5,
    parameter int CH_W      = 2
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [NREQ-1:0]   i_ch_req,
    input  logic [NREQ-1:0]   i_ch_bit,
    output logic [NREQ-1:0]   o_ch_grant,
    output logic              o_det_seq_in,
    input  logic              i_det_hit,
    output logic              o_res_valid,
    output logic [CH_W-1:0]   o_res_ch,
    output logic [CNT_W-1:0]  o_res_count,
    output logic              o_res_abort
);

    localparam int IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_STREAM,
        S_DRAIN,
        S_REPORT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic [CH_W-1:0]    r_owner;
    logic [CH_W-1:0]    w_owner_next;
    logic [CH_W-1:0]    r_rr_ptr;
    logic [CH_W-1:0]    w_rr_ptr_next;
    logic [CNT_W-1:0]   r_hits;
    logic [CNT_W-1:0]   w_hits_next;
    logic               r_abort;
    logic               w_abort_next;
    logic [CH_W-1:0]    r_res_ch;
    logic [CNT_W-1:0]   r_res_count;
    logic               r_res_abort;

    logic               w_any_req;
    logic [CH_W-1:0]    w_pick;
    logic               w_owner_req;
    logic               w_consume;
    logic               w_hits_full;
    logic               w_enter_report;

    // ------------------------------------------------------------------
    // Round-robin pick: scan from the farthest offset down to rr_ptr+1 so
    // that the nearest requesting channel after rr_ptr is the last write.
    // ------------------------------------------------------------------
    always_comb begin
        w_any_req = |i_ch_req;
        w_pick    = '0;
        for (int off = NREQ; off >= 1; off--) begin
            if (i_ch_req[(int'(r_rr_ptr) + off) % NREQ]) begin
                w_pick = CH_W'((int'(r_rr_ptr) + off) % NREQ);
            end
        end
    end

    assign w_owner_req = i_ch_req[r_owner];
    // A bit is consumed only while the owner still requests; a drop ends the
    // frame in that same cycle without taking its bit.
    assign w_consume   = (r_state == S_STREAM) && w_owner_req;
    assign w_hits_full = (r_hits == {CNT_W{1'b1}});

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
        assign o_ch_grant[gi] = w_consume && (r_owner == CH_W'(gi));
    end

    assign o_det_seq_in = (r_state == S_STREAM) ? i_ch_bit[r_owner] : 1'b0;
    assign o_res_valid  = (r_state == S_REPORT);
    assign o_res_ch     = r_res_ch;
    assign o_res_count  = r_res_count;
    assign o_res_abort  = r_res_abort;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_owner_next  = r_owner;
        w_rr_ptr_next = r_rr_ptr;
        w_hits_next   = r_hits;
        w_abort_next  = r_abort;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_owner_next = w_pick;
                    w_idx_next   = '0;
                    w_state_next = S_FLUSH;
                end
            end

            S_FLUSH: begin
                // Two zero bits return the detector to its idle state, so no
                // partial match leaks in from the previous frame.
                w_hits_next  = '0;
                w_abort_next = 1'b0;
                if (r_idx == IDX_W'(1)) begin
                    w_idx_next   = '0;
                    w_state_next = S_STREAM;
                end else begin
                    w_idx_next = r_idx + IDX_W'(1);
                end
            end

            S_STREAM: begin
                // det_hit in cycle k belongs to bit k-1, so k=0 is skipped.
                if ((r_idx != '0) && i_det_hit && !w_hits_full) begin
                    w_hits_next = r_hits + CNT_W'(1);
                end
                if (!w_owner_req) begin
                    w_abort_next = 1'b1;
                    w_state_next = S_REPORT;
                end else if (r_idx == IDX_W'(FRAME_LEN - 1)) begin
                    w_state_next = S_DRAIN;
                end else begin
                    w_idx_next = r_idx + IDX_W'(1);
                end
            end

            S_DRAIN: begin
                // Last sample, covering bit FRAME_LEN-1.
                if (i_det_hit && !w_hits_full) begin
                    w_hits_next = r_hits + CNT_W'(1);
                end
                w_state_next = S_REPORT;
            end

            S_REPORT: begin
                w_rr_ptr_next = r_owner;
                w_state_next  = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Result registers load on entry to REPORT so they are visible during
    // the strobe cycle and then hold until the next frame reports.
    assign w_enter_report = (r_state != S_REPORT) && (w_state_next == S_REPORT);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_idx       <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= CH_W'(NREQ - 1);
            r_hits      <= '0;
            r_abort     <= 1'b0;
            r_res_ch    <= '0;
            r_res_count <= '0;
            r_res_abort <= 1'b0;
        end else begin
            r_idx    <= w_idx_next;
            r_owner  <= w_owner_next;
            r_rr_ptr <= w_rr_ptr_next;
            r_hits   <= w_hits_next;
            r_abort  <= w_abort_next;
            if (w_enter_report) begin
                r_res_ch    <= r_owner;
                r_res_count <= w_hits_next;
                r_res_abort <= w_abort_next;
            end
        end
    end

endmodule
